// File: rtl/selector_write_arbiter_if.sv
// rtl/selector_write_arbiter_if.sv - requester-facing bus of the arbitrated selector register
interface selector_write_arbiter_if;
    logic [3:0]  req;
    logic [11:0] sel;
    logic [3:0]  gnt;
    logic        busy;
    logic [7:0]  my_reg;
    logic        err;
    logic [7:0]  write_count;

    modport master (
        output req, sel,
        input  gnt, busy, my_reg, err, write_count
    );

    modport slave (
        input  req, sel,
        output gnt, busy, my_reg, err, write_count
    );
endinterface

// File: rtl/selector_write_arbiter.sv
// rtl/selector_write_arbiter.sv - round-robin arbitrated writes of the selector-decoded constant register
module selector_write_arbiter #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    selector_write_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

    localparam logic [3:0] HOLD_INIT = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] winner_q, winner_d;
    logic [2:0] sel_q, sel_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] my_reg_q, my_reg_d;
    logic       err_q, err_d;
    logic [7:0] write_count_q, write_count_d;
    logic       busy_q, busy_d;

    logic [1:0] rr_pick;
    logic [1:0] rr_idx;
    logic       rr_found;
    logic [3:0] sel_base;
    logic [2:0] sel_pick;

    function automatic logic [7:0] decode(input logic [2:0] code);
        case (code)
            3'd0:    decode = 8'd17;
            3'd1:    decode = 8'd22;
            3'd2:    decode = 8'd30;
            default: decode = 8'd72;
        endcase
    endfunction

    // First requester at or after ptr_q, wrapping modulo 4.
    always_comb begin
        rr_pick  = ptr_q;
        rr_idx   = ptr_q;
        rr_found = 1'b0;
        for (int j = 0; j < 4; j++) begin
            rr_idx = ptr_q + 2'(j);
            if (!rr_found && bus.req[rr_idx]) begin
                rr_pick  = rr_idx;
                rr_found = 1'b1;
            end
        end
        sel_base = {1'b0, rr_pick, 1'b0} + {2'b00, rr_pick};
        sel_pick = bus.sel[sel_base +: 3];
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        winner_d      = winner_q;
        sel_d         = sel_q;
        hold_cnt_d    = hold_cnt_q;
        my_reg_d      = my_reg_q;
        err_d         = 1'b0;
        write_count_d = write_count_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d  = WRITE;
                    winner_d = rr_pick;
                    sel_d    = sel_pick;
                    ptr_d    = rr_pick + 2'd1;
                end
            end
            WRITE: begin
                if (sel_q != 3'd7) begin
                    my_reg_d      = decode(sel_q);
                    write_count_d = write_count_q + 8'd1;
                end else begin
                    err_d = 1'b1;
                end
                if (HOLD_CYCLES > 0) begin
                    state_d    = HOLD;
                    hold_cnt_d = HOLD_INIT;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (hold_cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= 2'd0;
            winner_q      <= 2'd0;
            sel_q         <= 3'd0;
            hold_cnt_q    <= 4'd0;
            my_reg_q      <= 8'd0;
            err_q         <= 1'b0;
            write_count_q <= 8'd0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            winner_q      <= winner_d;
            sel_q         <= sel_d;
            hold_cnt_q    <= hold_cnt_d;
            my_reg_q      <= my_reg_d;
            err_q         <= err_d;
            write_count_q <= write_count_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.gnt         = (state_q == WRITE) ? (4'b0001 << winner_q) : 4'b0000;
    assign bus.busy        = busy_q;
    assign bus.my_reg      = my_reg_q;
    assign bus.err         = err_q;
    assign bus.write_count = write_count_q;
endmodule

// File: tb/tb_selector_write_arbiter.sv
// tb/tb_selector_write_arbiter.sv - randomized and directed checks of selector_write_arbiter against a cycle-timeline model
module tb_selector_write_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    selector_write_arbiter_if if0 ();
    selector_write_arbiter_if if1 ();
    selector_write_arbiter_if if2 ();

    selector_write_arbiter #(.HOLD_CYCLES(2)) u_h2 (.clock(clock), .reset(reset), .bus(if0));
    selector_write_arbiter #(.HOLD_CYCLES(0)) u_h0 (.clock(clock), .reset(reset), .bus(if1));
    selector_write_arbiter #(.HOLD_CYCLES(3)) u_h3 (.clock(clock), .reset(reset), .bus(if2));

    localparam int HV [3] = '{2, 0, 3};

    logic [3:0]  req_a [3];
    logic [11:0] sel_a [3];
    assign if0.req = req_a[0];
    assign if1.req = req_a[1];
    assign if2.req = req_a[2];
    assign if0.sel = sel_a[0];
    assign if1.sel = sel_a[1];
    assign if2.sel = sel_a[2];

    logic [3:0] dut_gnt [3];
    logic       dut_busy [3];
    logic       dut_err [3];
    logic [7:0] dut_reg [3];
    logic [7:0] dut_cnt [3];
    assign dut_gnt[0]  = if0.gnt;          assign dut_gnt[1]  = if1.gnt;          assign dut_gnt[2]  = if2.gnt;
    assign dut_busy[0] = if0.busy;         assign dut_busy[1] = if1.busy;         assign dut_busy[2] = if2.busy;
    assign dut_err[0]  = if0.err;          assign dut_err[1]  = if1.err;          assign dut_err[2]  = if2.err;
    assign dut_reg[0]  = if0.my_reg;       assign dut_reg[1]  = if1.my_reg;       assign dut_reg[2]  = if2.my_reg;
    assign dut_cnt[0]  = if0.write_count;  assign dut_cnt[1]  = if1.write_count;  assign dut_cnt[2]  = if2.write_count;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_value(input logic [2:0] code);
        if (code == 3'd0)      return 8'd17;
        else if (code == 3'd1) return 8'd22;
        else if (code == 3'd2) return 8'd30;
        else                   return 8'd72;
    endfunction

    // Model: edges are numbered after reset; a grant at edge e writes at e+1
    // and the next arbitration may happen no earlier than edge e+2+HOLD.
    int         e;
    int         idle_from [3];
    int         pend_e [3];
    logic [2:0] pend_code [3];
    int         mptr [3];
    logic [3:0] exp_gnt [3];
    logic       exp_busy [3];
    logic       exp_err [3];
    logic [7:0] exp_reg [3];
    logic [7:0] exp_cnt [3];
    int         m_w;
    int         m_found;

    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            e = 0;
            for (int k = 0; k < 3; k++) begin
                idle_from[k] = 0; pend_e[k] = -1; pend_code[k] = 3'd0; mptr[k] = 0;
                exp_gnt[k] = 4'd0; exp_busy[k] = 1'b0; exp_err[k] = 1'b0;
                exp_reg[k] = 8'd0; exp_cnt[k] = 8'd0;
            end
        end else begin
            e++;
            for (int k = 0; k < 3; k++) begin
                exp_gnt[k] = 4'd0;
                exp_err[k] = 1'b0;
                if (pend_e[k] == e) begin
                    if (pend_code[k] != 3'd7) begin
                        exp_reg[k] = ref_value(pend_code[k]);
                        exp_cnt[k] = exp_cnt[k] + 8'd1;
                    end else begin
                        exp_err[k] = 1'b1;
                    end
                end
                if (e >= idle_from[k] && req_a[k] != 4'd0) begin
                    m_found = 0;
                    m_w = 0;
                    for (int j = 0; j < 4; j++) begin
                        if (m_found == 0 && req_a[k][(mptr[k] + j) % 4]) begin
                            m_w = (mptr[k] + j) % 4;
                            m_found = 1;
                        end
                    end
                    exp_gnt[k]   = 4'(1 << m_w);
                    mptr[k]      = (m_w + 1) % 4;
                    pend_e[k]    = e + 1;
                    pend_code[k] = sel_a[k][3*m_w +: 3];
                    idle_from[k] = e + 2 + HV[k];
                end
                exp_busy[k] = (e < idle_from[k] - 1);
            end
        end
    end

    initial forever begin
        @(negedge clock);
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                chk("gnt", k, dut_gnt[k], exp_gnt[k]);
                chk("busy", k, dut_busy[k], exp_busy[k]);
                chk("err", k, dut_err[k], exp_err[k]);
                chk("my_reg", k, dut_reg[k], exp_reg[k]);
                chk("write_count", k, dut_cnt[k], exp_cnt[k]);
            end
        end
    end

    logic auto_drop = 1'b1;

    task automatic tick();
        @(posedge clock);
        #1;
        if (auto_drop) begin
            for (int k = 0; k < 3; k++)
                for (int i = 0; i < 4; i++)
                    if (exp_gnt[k][i]) req_a[k][i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
    endtask

    task automatic wait_gnt(input int k, input int maxc, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (dut_gnt[k] == 4'd0 && n < maxc);
        chk("gnt_seen", k, (dut_gnt[k] != 4'd0), 1);
    endtask

    int w;
    int pulses;
    int fair_reg [4] = '{17, 30, 72, 72};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            req_a[k] = 4'd0;
            sel_a[k] = 12'd0;
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        #2 reset = 1'b0;

        chk("rst_gnt", 0, if0.gnt, 0);
        chk("rst_busy", 0, if0.busy, 0);
        chk("rst_reg", 0, if0.my_reg, 0);
        chk("rst_err", 0, if0.err, 0);
        chk("rst_cnt", 0, if0.write_count, 0);

        sel_a[0] = 12'd1;
        req_a[0] = 4'b0001;
        tick();
        chk("single_gnt", 0, if0.gnt, 4'b0001);
        chk("single_busy", 0, if0.busy, 1);
        tick();
        chk("single_reg", 0, if0.my_reg, 22);
        chk("single_cnt", 0, if0.write_count, 1);
        chk("single_gnt_off", 0, if0.gnt, 0);
        tick();
        chk("single_busy_hold", 0, if0.busy, 1);
        tick();
        chk("single_busy_done", 0, if0.busy, 0);

        do_reset();
        sel_a[0] = {3'd6, 3'd3, 3'd2, 3'd0};
        req_a[0] = 4'b1111;
        for (int n = 0; n < 4; n++) begin
            wait_gnt(0, 8, w);
            chk("fair_gnt", n, if0.gnt, 32'(1 << n));
            tick();
            chk("fair_reg", n, if0.my_reg, fair_reg[n]);
        end
        repeat (4) tick();
        req_a[0] = 4'b1001;
        wait_gnt(0, 8, w);
        chk("ptr_wrap_gnt", 0, if0.gnt, 4'b0001);
        req_a[0] = 4'b0000;
        repeat (4) tick();

        sel_a[0][8:6] = 3'd7;
        req_a[0] = 4'b0100;
        wait_gnt(0, 8, w);
        chk("inv_gnt", 0, if0.gnt, 4'b0100);
        tick();
        chk("inv_err", 0, if0.err, 1);
        chk("inv_reg", 0, if0.my_reg, 17);
        chk("inv_cnt", 0, if0.write_count, 5);
        tick();
        chk("inv_err_clear", 0, if0.err, 0);

        repeat (4) tick();
        sel_a[0][5:3] = 3'd2;
        req_a[0] = 4'b0010;
        wait_gnt(0, 8, w);
        chk("abort_gnt", 0, if0.gnt, 4'b0010);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("abort_gnt_rst", 0, if0.gnt, 0);
        chk("abort_busy_rst", 0, if0.busy, 0);
        chk("abort_reg_rst", 0, if0.my_reg, 0);
        chk("abort_cnt_rst", 0, if0.write_count, 0);
        req_a[0] = 4'b0000;
        @(posedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
        tick();
        chk("abort_no_write_reg", 0, if0.my_reg, 0);
        chk("abort_no_write_cnt", 0, if0.write_count, 0);
        req_a[0] = 4'b1001;
        wait_gnt(0, 8, w);
        chk("abort_first_gnt", 0, if0.gnt, 4'b0001);
        req_a[0] = 4'b0000;
        repeat (5) tick();

        do_reset();
        auto_drop = 1'b0;
        sel_a[1] = 12'd1;
        req_a[1] = 4'b0001;
        pulses = 0;
        for (int i = 1; i <= 512; i++) begin
            tick();
            if (dut_gnt[1] != 4'd0) pulses++;
            if (i == 511) chk("wrap_255", 1, dut_cnt[1], 255);
        end
        chk("wrap_pulses", 1, pulses, 256);
        chk("wrap_zero", 1, dut_cnt[1], 0);
        req_a[1] = 4'b0000;
        auto_drop = 1'b1;
        repeat (3) tick();

        sel_a[2] = 12'd0;
        req_a[2] = 4'b0001;
        wait_gnt(2, 8, w);
        chk("hold_first_gnt", 2, dut_gnt[2], 4'b0001);
        tick();
        req_a[2] = 4'b0010;
        wait_gnt(2, 10, w);
        chk("hold_wait", 2, w, 4);
        chk("hold_second_gnt", 2, dut_gnt[2], 4'b0010);
        repeat (6) tick();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 4; i++) begin
                    if (req_a[k][i]) begin
                        if ($urandom % 50 == 0) req_a[k][i] = 1'b0;
                    end else begin
                        sel_a[k][3*i +: 3] = 3'($urandom);
                        if ($urandom % 3 == 0) req_a[k][i] = 1'b1;
                    end
                end
            end
            if (cyc % 900 == 450) begin
                @(negedge clock);
                #2 reset = 1'b1;
                @(posedge clock);
                @(negedge clock);
                #2 reset = 1'b0;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/selector_write_arbiter.md
# selector_write_arbiter

Shares the selector-decoded 8-bit constant register (`my_reg`) between four requesters. Each requester presents a 3-bit selector code. A round-robin arbiter picks one pending request, and a small FSM sequences the write. The FSM then holds off for a programmable quiet period before arbitrating again. The block sits in front of the switch-decoded register, replacing its single-selector `tock()` path with arbitrated access.

## Interface
Parameters:
- `HOLD_CYCLES`, default 2: quiet cycles after each write before the next arbitration. Legal range 0..15.

Ports:
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high. Clears all state immediately.
- `req` input 4: per-requester request. Held high until that requester's `gnt` pulse.
- `sel` input 12: selector codes, 3 bits per requester. Requester i uses `sel[3i+2:3i]`.
- `gnt` output 4: one-hot grant/acknowledge pulse, one cycle long.
- `busy` output 1: high whenever the FSM is not IDLE.
- `my_reg` output 8: the shared register.
- `err` output 1: one-cycle pulse when the granted selector code is invalid (7).
- `write_count` output 8: number of valid writes, wraps modulo 256.

## Operation
- Selector decode:
  - 0 → 17
  - 1 → 22
  - 2 → 30
  - 3, 4, 5, 6 → 72
  - 7 → invalid: no write, `err` pulses, `write_count` unchanged.
- Registered state:
  - `state` ∈ {IDLE, WRITE, HOLD}
  - `ptr[1:0]`: round-robin start index
  - `winner[1:0]`
  - `sel_q[2:0]`
  - `hold_cnt[3:0]`
  - `my_reg`, `err`, `write_count`
- Round robin:
  - In IDLE with any `req` bit high, the winner is the first set bit scanning `ptr`, `ptr+1`, … mod 4.
  - On entering WRITE, `ptr` ← winner+1 mod 4.
- IDLE → WRITE when `|req`. Latch `winner` and that requester's `sel` into `sel_q`. Otherwise stay in IDLE.
- WRITE (always exactly 1 cycle):
  - `gnt[winner]`=1 (combinational from state/winner).
  - At the closing edge:
    - If `sel_q`≠7: `my_reg` ← decode(`sel_q`), `write_count` += 1.
    - Else: `err` ← 1.
  - Next state:
    - HOLD with `hold_cnt` ← HOLD_CYCLES−1 if HOLD_CYCLES>0.
    - IDLE otherwise.
- HOLD:
  - Decrement `hold_cnt`.
  - Go to IDLE on the edge where `hold_cnt`==0.
  - `req` is ignored in HOLD.
- `err` is set only by a WRITE with code 7 and clears on every other edge.
- `gnt` is zero outside WRITE.
- `busy` = (state≠IDLE).
- The `req`/`sel` of non-granted requesters may change freely. A requester that drops `req` before its grant is simply not served. There is no error for this.
- Reset values:
  - state=IDLE, ptr=0, winner=0, sel_q=0, hold_cnt=0
  - my_reg=0, err=0, write_count=0
  - gnt=0, busy=0
- Reset asserted during WRITE or HOLD aborts the sequence. No write occurs if the closing edge of WRITE has not happened.

## Timing
- Sample edge: request seen in IDLE during cycle c.
- Cycle c+1: state WRITE, `gnt`, `busy`=1.
- Cycle c+2: new `my_reg`/`write_count` or `err` pulse visible.
- Write-to-write spacing is at least 2+HOLD_CYCLES cycles. With HOLD_CYCLES=0, back-to-back writes occur every 2 cycles.
- The requester must deassert `req` in the cycle after its `gnt` (c+2). If it is still high when the FSM next reaches IDLE, it is treated as a new request.
- `write_count` 255 + valid write → 0, with no flag.
- Simultaneous requests: exactly one grant per WRITE, chosen by the round-robin order from `ptr`.

## Test plan
- Reset then single request: `req`=0001, `sel[2:0]`=1.
  - `gnt`=0001 at c+1.
  - `my_reg`=22 and `write_count`=1 at c+2.
  - `busy` low again at c+4 (HOLD_CYCLES=2).
- Fairness: `req`=1111 held continuously, with each requester dropping its `req` after its grant, using codes 0, 2, 3, 6.
  - Grants in order 0001, 0010, 0100, 1000.
  - `my_reg` sequence 17, 30, 72, 72.
  - `ptr` wraps to 0.
- Invalid code: `sel`=7 on requester 2.
  - `gnt`=0100.
  - `err`=1 for one cycle.
  - `my_reg` and `write_count` unchanged.
- Async reset mid-WRITE: assert `reset` between edges during WRITE.
  - All outputs go to 0 immediately.
  - No write follows.
  - A request after reset release is granted to requester 0 first.
- Counter wrap: 256 valid writes → `write_count`=0.
- HOLD_CYCLES=0: continuous `req`=0001 gives a `gnt` pulse every 2 cycles. Requests arriving during HOLD (HOLD_CYCLES=3) are not granted until IDLE.
